// File: rtl/cv32e40s_shadow_reg_pkg.sv
// Shared types and constants for the hardened shadow register.
package cv32e40s_shadow_reg_pkg;

    typedef enum logic [0:0] {
        SR_IDLE      = 1'b0,
        SR_WR_SHADOW = 1'b1
    } shadow_reg_state_e;

    localparam int unsigned MISM_CNT_W = 8;
    localparam logic [MISM_CNT_W-1:0] MISM_CNT_MAX = '1;

    function automatic logic [MISM_CNT_W-1:0] mism_cnt_inc(input logic [MISM_CNT_W-1:0] v);
        return (v == MISM_CNT_MAX) ? v : v + MISM_CNT_W'(1);
    endfunction

endpackage

// File: rtl/cv32e40s_shadow_reg_cmp.sv
// Main/shadow comparator with alert register and mismatch-event edge detector.
// CV32E40S_SHADOW_REG_ALERT_FILTER_EN: require two consecutive raw mismatches.
module cv32e40s_shadow_reg_cmp
    import cv32e40s_shadow_reg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_main,
    input  logic [WIDTH-1:0] i_shadow,
    input  logic             i_idle,
    output logic             o_alert,
    output logic             o_event
);

    logic w_raw;
    logic w_qual;
    logic r_alert;

    // Shadow lags main by one cycle during a write, so only compare in idle.
    assign w_raw = i_idle & (i_main != ~i_shadow);

`ifdef CV32E40S_SHADOW_REG_ALERT_FILTER_EN
    logic r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 1'b0;
        end else begin
            r_hist <= i_idle ? w_raw : 1'b0;
        end
    end

    assign w_qual = w_raw & r_hist;
`else
    assign w_qual = w_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alert <= 1'b0;
        end else begin
            r_alert <= w_qual;
        end
    end

    // r_alert holds last cycle's qualified mismatch, doubling as the edge history.
    assign o_event = w_qual & ~r_alert;
    assign o_alert = r_alert;

endmodule

// File: rtl/cv32e40s_shadow_reg.sv
// Hardened register: main copy plus inverted shadow, written in two phases.
// Optional CV32E40S_SHADOW_REG_ALERT_FILTER_EN debounces the alert (see _cmp).
module cv32e40s_shadow_reg
    import cv32e40s_shadow_reg_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [WIDTH-1:0]      wr_data_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  alert_major_o,
    output logic                  err_sticky_o,
    input  logic                  err_clr_i,
    output logic [MISM_CNT_W-1:0] mism_cnt_o
);

    shadow_reg_state_e     r_state;
    logic [WIDTH-1:0]      r_main;
    logic [WIDTH-1:0]      r_shadow;
    logic [WIDTH-1:0]      r_wdata;
    logic                  r_sticky;
    logic [MISM_CNT_W-1:0] r_cnt;

    logic w_idle;
    logic w_accept;
    logic w_event;

    assign w_idle   = (r_state == SR_IDLE);
    assign w_accept = wr_valid_i & w_idle;

    // Shadow is built from a private copy of the write data, not from main,
    // so a fault hitting main between the phases is not copied into shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= SR_IDLE;
            r_main   <= RESET_VAL;
            r_shadow <= ~RESET_VAL;
            r_wdata  <= RESET_VAL;
        end else begin
            case (r_state)
                SR_IDLE: begin
                    if (w_accept) begin
                        r_main  <= wr_data_i;
                        r_wdata <= wr_data_i;
                        r_state <= SR_WR_SHADOW;
                    end
                end
                SR_WR_SHADOW: begin
                    r_shadow <= ~r_wdata;
                    r_state  <= SR_IDLE;
                end
                default: r_state <= SR_IDLE;
            endcase
        end
    end

    cv32e40s_shadow_reg_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .clk      (clk),
        .rst      (rst),
        .i_main   (r_main),
        .i_shadow (r_shadow),
        .i_idle   (w_idle),
        .o_alert  (alert_major_o),
        .o_event  (w_event)
    );

    // A new event beats a simultaneous clear so it is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (w_event) begin
            r_sticky <= 1'b1;
            r_cnt    <= err_clr_i ? MISM_CNT_W'(1) : mism_cnt_inc(r_cnt);
        end else if (err_clr_i) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end
    end

    assign wr_ready_o   = w_idle;
    assign rd_data_o    = r_main;
    assign err_sticky_o = r_sticky;
    assign mism_cnt_o   = r_cnt;

endmodule
